// File: rtl/cram_pkg.sv
// Shared definitions for the CRAM loader: command encodings, word geometry
// and FSM state type.
package cram_pkg;

  typedef enum logic [1:0] {
    OP_SET_ADDR   = 2'd0,
    OP_DATA       = 2'd1,
    OP_ABORT      = 2'd2,
    OP_CLR_STATUS = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam int WORD_W          = 84;
  localparam int CRAM_ADDR_W     = 12;
  localparam int CHUNKS_PER_WORD = 4;
  localparam int WCNT_W          = 13;

endpackage

// File: rtl/cram_loader.sv
// Assembles four command-stream chunks into one CRAM word and writes it at an
// auto-incrementing load address, with sticky status for discards and wraps.
module cram_loader
  import cram_pkg::*;
#(
  parameter int ADDR_W  = CRAM_ADDR_W,
  parameter int CHUNK_W = 21
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [CHUNK_W-1:0]  cmd_data,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [WORD_W-1:0]   wr_data,
  output logic                wr_en,
  output logic                busy,
  output logic [WCNT_W-1:0]   words_written,
  output logic                partial_err,
  output logic                wrap_flag
);

  localparam logic [1:0]        LAST_CHUNK = 2'(CHUNKS_PER_WORD - 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX   = '1;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   data_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic                perr_q;
  logic                wrap_q;
  logic                fire;
  cmd_op_e             op;

  assign op   = cmd_op_e'(cmd_op);
  assign fire = cmd_valid && cmd_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b1;
    wr_en     = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        busy = (state_q != ST_IDLE);
        if (fire) begin
          case (op)
            OP_DATA:               state_d = (cnt_q == LAST_CHUNK) ? ST_WRITE : ST_ACCUM;
            OP_SET_ADDR, OP_ABORT: state_d = ST_IDLE;
            default:               state_d = state_q;
          endcase
        end
      end
      ST_WRITE: begin
        cmd_ready = 1'b0;
        wr_en     = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Chunks shift in from the bottom, so the first chunk ends up in the MSBs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      wcnt_q <= '0;
      perr_q <= 1'b0;
      wrap_q <= 1'b0;
    end else if (state_q == ST_WRITE) begin
      addr_q <= addr_q + 1'b1;
      cnt_q  <= '0;
      if (&addr_q)             wrap_q <= 1'b1;
      if (wcnt_q != WCNT_MAX)  wcnt_q <= wcnt_q + 1'b1;
    end else if (fire) begin
      case (op)
        OP_DATA: begin
          data_q <= {data_q[WORD_W-CHUNK_W-1:0], cmd_data};
          cnt_q  <= cnt_q + 1'b1;
        end
        OP_SET_ADDR: begin
          addr_q <= cmd_data[ADDR_W-1:0];
          cnt_q  <= '0;
          if (state_q == ST_ACCUM) perr_q <= 1'b1;
        end
        OP_ABORT: begin
          cnt_q <= '0;
          if (state_q == ST_ACCUM) perr_q <= 1'b1;
        end
        OP_CLR_STATUS: begin
          perr_q <= 1'b0;
          wrap_q <= 1'b0;
          wcnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign wr_addr       = addr_q;
  assign wr_data       = data_q;
  assign words_written = wcnt_q;
  assign partial_err   = perr_q;
  assign wrap_flag     = wrap_q;

endmodule

// File: tb/tb_cram_loader.sv
// Directed bench for cram_loader: hand-computed vectors for addressing,
// chunk assembly, back-to-back flow control, status bits and reset.
module tb_cram_loader;
  import cram_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [20:0]       cmd_data;
  logic [11:0]       wr_addr;
  logic [83:0]       wr_data;
  logic              wr_en;
  logic              busy;
  logic [12:0]       words_written;
  logic              partial_err;
  logic              wrap_flag;

  int checks = 0;
  int errors = 0;

  logic [11:0] wq_addr[$];
  logic [83:0] wq_data[$];

  cram_loader dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .busy(busy), .words_written(words_written),
    .partial_err(partial_err), .wrap_flag(wrap_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
  end

  task automatic chk(input string tag, input logic [83:0] obs, input logic [83:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // Returns at posedge+1 of the transfer edge, i.e. inside the following cycle.
  task automatic send(input logic [1:0] op, input logic [20:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("send_timeout", 84'(cmd_ready), 84'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic word4(input logic [20:0] a, input logic [20:0] b,
                       input logic [20:0] c, input logic [20:0] d);
    send(OP_DATA, a); send(OP_DATA, b); send(OP_DATA, c); send(OP_DATA, d);
  endtask

  logic [20:0] v [8];
  logic [9:0]  rp, wp;
  int          base, idx, sent;
  logic        fire;

  initial begin
    v = '{21'h0AAAAA, 21'h000001, 21'h100000, 21'h012345,
          21'h1ABCDE, 21'h000F0F, 21'h0F0F00, 21'h1FFFFE};
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
    #12;
    chk("rst_wr_en",   84'(wr_en), 84'd0);
    chk("rst_busy",    84'(busy), 84'd0);
    chk("rst_addr",    84'(wr_addr), 84'd0);
    chk("rst_data",    wr_data, 84'd0);
    chk("rst_wcnt",    84'(words_written), 84'd0);
    chk("rst_perr",    84'(partial_err), 84'd0);
    chk("rst_wrap",    84'(wrap_flag), 84'd0);
    @(negedge clk); reset = 1'b0;
    #1 chk("rst_ready", 84'(cmd_ready), 84'd1);

    // basic word at octal 100
    base = wq_addr.size();
    send(OP_SET_ADDR, 21'o100);
    send(OP_DATA, 21'h1FFFFF); send(OP_DATA, 21'h0); send(OP_DATA, 21'h155555);
    chk("w1_ready_acc", 84'(cmd_ready), 84'd1);
    chk("w1_busy_acc",  84'(busy), 84'd1);
    send(OP_DATA, 21'h1);
    chk("w1_wr_en_n1",  84'(wr_en), 84'd1);
    chk("w1_ready_n1",  84'(cmd_ready), 84'd0);
    chk("w1_addr_n1",   84'(wr_addr), 84'o100);
    chk("w1_data_n1",   wr_data, {21'h1FFFFF, 21'h0, 21'h155555, 21'h1});
    @(posedge clk); #1;
    chk("w1_wr_en_n2",  84'(wr_en), 84'd0);
    chk("w1_ready_n2",  84'(cmd_ready), 84'd1);
    chk("w1_busy_n2",   84'(busy), 84'd0);
    word4(21'h3, 21'h2, 21'h1, 21'h0);
    @(posedge clk); #1;
    chk("w1_nwr", 84'(wq_addr.size() - base), 84'd2);
    if (wq_addr.size() >= base + 2) begin
      chk("w1_q0_addr", 84'(wq_addr[base]), 84'o100);
      chk("w1_q1_addr", 84'(wq_addr[base+1]), 84'o101);
      chk("w1_q1_data", wq_data[base+1], {21'h3, 21'h2, 21'h1, 21'h0});
    end
    chk("w1_wcnt", 84'(words_written), 84'd2);

    // wrap at 4095
    send(OP_CLR_STATUS, 21'h0);
    chk("clr_wcnt", 84'(words_written), 84'd0);
    base = wq_addr.size();
    send(OP_SET_ADDR, 21'd4095);
    word4(21'h10, 21'h11, 21'h12, 21'h13);
    word4(21'h20, 21'h21, 21'h22, 21'h23);
    @(posedge clk); #1;
    chk("wrap_nwr", 84'(wq_addr.size() - base), 84'd2);
    if (wq_addr.size() >= base + 2) begin
      chk("wrap_q0_addr", 84'(wq_addr[base]), 84'd4095);
      chk("wrap_q1_addr", 84'(wq_addr[base+1]), 84'd0);
    end
    chk("wrap_flag", 84'(wrap_flag), 84'd1);
    chk("wrap_wcnt", 84'(words_written), 84'd2);
    chk("wrap_addr", 84'(wr_addr), 84'd1);

    // partial word discarded by SET_ADDR
    send(OP_CLR_STATUS, 21'h0);
    chk("clr_wrap", 84'(wrap_flag), 84'd0);
    base = wq_addr.size();
    send(OP_SET_ADDR, 21'd10);
    chk("perr_idle_set", 84'(partial_err), 84'd0);
    send(OP_DATA, 21'h5); send(OP_DATA, 21'h6);
    send(OP_SET_ADDR, 21'd20);
    chk("perr_set", 84'(partial_err), 84'd1);
    chk("perr_busy", 84'(busy), 84'd0);
    word4(21'h7, 21'h8, 21'h9, 21'hA);
    @(posedge clk); #1;
    chk("perr_nwr", 84'(wq_addr.size() - base), 84'd1);
    if (wq_addr.size() >= base + 1) begin
      chk("perr_q0_addr", 84'(wq_addr[base]), 84'd20);
      chk("perr_q0_data", wq_data[base], {21'h7, 21'h8, 21'h9, 21'hA});
    end

    // back-to-back DATA with cmd_valid held high
    send(OP_SET_ADDR, 21'd100);
    base = wq_addr.size();
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rp[c] = cmd_ready; wp[c] = wr_en;
      cmd_valid = (idx < 8); cmd_op = OP_DATA; cmd_data = v[idx & 7];
      fire = cmd_valid && cmd_ready;
      @(posedge clk);
      if (fire) idx++;
    end
    #1 cmd_valid = 1'b0;
    chk("b2b_ready_pat", 84'(rp), 84'(10'b0111101111));
    chk("b2b_wr_en_pat", 84'(wp), 84'(10'b1000010000));
    chk("b2b_nwr", 84'(wq_addr.size() - base), 84'd2);
    if (wq_addr.size() >= base + 2) begin
      chk("b2b_q0_addr", 84'(wq_addr[base]), 84'd100);
      chk("b2b_q0_data", wq_data[base], {v[0], v[1], v[2], v[3]});
      chk("b2b_q1_addr", 84'(wq_addr[base+1]), 84'd101);
      chk("b2b_q1_data", wq_data[base+1], {v[4], v[5], v[6], v[7]});
    end

    // words_written saturation: 8200 words from address 0
    send(OP_CLR_STATUS, 21'h0);
    send(OP_SET_ADDR, 21'd0);
    sent = 0;
    while (sent < 8200 * 4) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_DATA; cmd_data = 21'(sent);
      fire = cmd_ready;
      @(posedge clk);
      if (fire) sent++;
    end
    #1 cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("sat_wcnt", 84'(words_written), 84'd8191);
    chk("sat_addr", 84'(wr_addr), 84'd8);
    chk("sat_wrap", 84'(wrap_flag), 84'd1);

    // ABORT after three chunks, then CLR_STATUS
    send(OP_CLR_STATUS, 21'h0);
    send(OP_SET_ADDR, 21'd30);
    base = wq_addr.size();
    send(OP_DATA, 21'h1); send(OP_DATA, 21'h2); send(OP_DATA, 21'h3);
    send(OP_ABORT, 21'h0);
    chk("abort_perr", 84'(partial_err), 84'd1);
    chk("abort_busy", 84'(busy), 84'd0);
    chk("abort_addr", 84'(wr_addr), 84'd30);
    send(OP_CLR_STATUS, 21'h0);
    chk("abort_clr_perr", 84'(partial_err), 84'd0);
    chk("abort_nwr", 84'(wq_addr.size() - base), 84'd0);
    word4(21'h44, 21'h55, 21'h66, 21'h77);
    @(posedge clk); #1;
    chk("abort_nwr2", 84'(wq_addr.size() - base), 84'd1);
    if (wq_addr.size() >= base + 1) begin
      chk("abort_q0_addr", 84'(wq_addr[base]), 84'd30);
      chk("abort_q0_data", wq_data[base], {21'h44, 21'h55, 21'h66, 21'h77});
    end

    // reset during the wr_en cycle
    send(OP_SET_ADDR, 21'd5);
    base = wq_addr.size();
    word4(21'h9, 21'h9, 21'h9, 21'h9);
    chk("rw_wr_en_before", 84'(wr_en), 84'd1);
    #2 reset = 1'b1;
    #1;
    chk("rw_wr_en", 84'(wr_en), 84'd0);
    chk("rw_busy",  84'(busy), 84'd0);
    chk("rw_addr",  84'(wr_addr), 84'd0);
    chk("rw_data",  wr_data, 84'd0);
    chk("rw_wcnt",  84'(words_written), 84'd0);
    chk("rw_perr",  84'(partial_err), 84'd0);
    chk("rw_wrap",  84'(wrap_flag), 84'd0);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rw_ready", 84'(cmd_ready), 84'd1);
    chk("rw_nwr",   84'(wq_addr.size() - base), 84'd0);
    @(posedge clk); #1;
    chk("rw_addr_hold", 84'(wr_addr), 84'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
